// File: rtl/assay_pkg.sv
// Shared types and constants for the assay stage sequencer.
package assay_pkg;
  typedef enum logic [2:0] {IDLE, RUN, WAIT_DET, DONE, ERR} state_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_DET_FAIL    = 2'd1;
  localparam logic [1:0] ERR_DET_TIMEOUT = 2'd2;

  localparam int DWELL_W_DEF = 16;
endpackage

// File: rtl/stage_dwell_timer.sv
// Loadable counter with freeze and a terminal flag; counts down for dwells,
// up for the detector timeout.
module stage_dwell_timer #(
  parameter int W  = 16,
  parameter bit UP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         cnt_en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  output logic         term_o
);
  logic [W-1:0] count_q, count_d;

  // Terminal only fires on a counting cycle, so a frozen counter never expires.
  assign term_o = cnt_en && (count_q == term_val);

  always_comb begin
    count_d = count_q;
    if (clr)                     count_d = '0;
    else if (load)               count_d = load_val;
    else if (cnt_en && !term_o)  count_d = UP ? count_q + 1'b1 : count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/assay_stage_sequencer.sv
// Steps the assay network stage by stage with per-stage dwell, and gates one
// stage on a detector verdict with a timeout.
module assay_stage_sequencer import assay_pkg::*; #(
  parameter int N_STAGES    = 5,
  parameter int DWELL_W     = DWELL_W_DEF,
  parameter int DET_STAGE   = 1,
  parameter int DET_TIMEOUT = 1000,
  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        hold,
  input  logic [N_STAGES*DWELL_W-1:0] dwell_cfg,
  input  logic                        det_valid,
  input  logic                        det_ok,
  output logic [N_STAGES-1:0]         stage_en,
  output logic [IW-1:0]               stage_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code
);
  localparam int TW = $clog2(DET_TIMEOUT + 1);
  localparam logic [N_STAGES-1:0] EN0 = N_STAGES'(1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, ld_idx;
  logic [N_STAGES-1:0]   en_q, en_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  dw_load, dw_term, to_clr, to_term, tmr_clr, adv;
  logic [DWELL_W-1:0]    dw_raw, dw_val;

  // A zero dwell still occupies one cycle.
  assign dw_raw = dwell_cfg[int'(ld_idx)*DWELL_W +: DWELL_W];
  assign dw_val = (dw_raw == '0) ? DWELL_W'(1) : dw_raw;

  stage_dwell_timer #(.W(DWELL_W), .UP(1'b0)) u_dwell (
    .clk(clk), .rst(rst), .clr(tmr_clr), .load(dw_load),
    .cnt_en((state_q == RUN) && !hold), .load_val(dw_val),
    .term_val(DWELL_W'(1)), .term_o(dw_term)
  );

  stage_dwell_timer #(.W(TW), .UP(1'b1)) u_tmo (
    .clk(clk), .rst(rst), .clr(tmr_clr | to_clr), .load(1'b0),
    .cnt_en((state_q == WAIT_DET) && !hold), .load_val('0),
    .term_val(TW'(DET_TIMEOUT - 1)), .term_o(to_term)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    ld_idx  = idx_q;
    dw_load = 1'b0;
    to_clr  = 1'b0;
    tmr_clr = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = RUN;
        idx_d   = '0;
        en_d    = EN0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        ld_idx  = '0;
        dw_load = 1'b1;
      end
      RUN: if (dw_term) begin
        if (int'(idx_q) == DET_STAGE) begin
          state_d = WAIT_DET;
          to_clr  = 1'b1;
        end else adv = 1'b1;
      end
      // Detector verdict outranks a timeout landing in the same cycle.
      WAIT_DET: if (det_valid) begin
        if (det_ok) adv = 1'b1;
        else begin
          state_d = ERR;
          en_d    = '0;
          err_d   = 1'b1;
          code_d  = ERR_DET_FAIL;
        end
      end else if (to_term) begin
        state_d = ERR;
        en_d    = '0;
        err_d   = 1'b1;
        code_d  = ERR_DET_TIMEOUT;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (int'(idx_q) == N_STAGES - 1) begin
        state_d = DONE;
        en_d    = '0;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        idx_d   = idx_q + 1'b1;
        en_d    = EN0 << (idx_q + 1'b1);
        ld_idx  = idx_q + 1'b1;
        dw_load = 1'b1;
      end
    end
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      en_d    = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      dw_load = 1'b0;
      tmr_clr = 1'b1;
    end
    busy_d = (state_d == RUN) || (state_d == WAIT_DET);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign stage_en  = en_q;
  assign stage_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;
endmodule
